// File: rtl/rscpu_control_unit.sv
// ---------------------------------------------------------------------------
// rscpu_control_unit
//
// Hardwired control unit for the Relatively Simple CPU. It runs the
// fetch/decode/execute state machine over the 16-instruction set and decodes
// the datapath control strobes, bus source select and ALU function select
// from the current state (Moore outputs). The one exception is that load and
// increment strobes in memory-read states are qualified by memory readiness.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ir_in      current IR contents (opcode)
//   z_in       Z flag from the datapath, sampled in FETCH3 for JMPZ/JPNZ
//   mem_ready  memory read/write completes this cycle
//   ALUSEL     ALU function select, bits [7:1]
//   bus_sel    bus source: 0 NONE, 1 MEM, 2 PC, 3 DR:TR, 4 DR, 5 R, 6 AC
//   ar_ld .. z_ld   datapath register load/increment controls
//   mem_rd, mem_wr  memory strobes
//   state_dbg  current state encoding
// ---------------------------------------------------------------------------
module rscpu_control_unit #(
    parameter int USE_MEM_READY = 1,
    parameter int STATE_W       = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         ir_in,
    input  logic               z_in,
    input  logic               mem_ready,
    output logic [7:1]         ALUSEL,
    output logic [2:0]         bus_sel,
    output logic               ar_ld,
    output logic               ar_inc,
    output logic               pc_ld,
    output logic               pc_inc,
    output logic               dr_ld,
    output logic               tr_ld,
    output logic               ir_ld,
    output logic               r_ld,
    output logic               ac_ld,
    output logic               z_ld,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [STATE_W-1:0] S_RST  = STATE_W'(0);
    localparam logic [STATE_W-1:0] FETCH1 = STATE_W'(1);
    localparam logic [STATE_W-1:0] FETCH2 = STATE_W'(2);
    localparam logic [STATE_W-1:0] FETCH3 = STATE_W'(3);
    localparam logic [STATE_W-1:0] NOP1   = STATE_W'(4);
    localparam logic [STATE_W-1:0] LDAC1  = STATE_W'(5);
    localparam logic [STATE_W-1:0] LDAC2  = STATE_W'(6);
    localparam logic [STATE_W-1:0] LDAC3  = STATE_W'(7);
    localparam logic [STATE_W-1:0] LDAC4  = STATE_W'(8);
    localparam logic [STATE_W-1:0] LDAC5  = STATE_W'(9);
    localparam logic [STATE_W-1:0] STAC1  = STATE_W'(10);
    localparam logic [STATE_W-1:0] STAC2  = STATE_W'(11);
    localparam logic [STATE_W-1:0] STAC3  = STATE_W'(12);
    localparam logic [STATE_W-1:0] STAC4  = STATE_W'(13);
    localparam logic [STATE_W-1:0] STAC5  = STATE_W'(14);
    localparam logic [STATE_W-1:0] MVAC1  = STATE_W'(15);
    localparam logic [STATE_W-1:0] MOVR1  = STATE_W'(16);
    localparam logic [STATE_W-1:0] JUMP1  = STATE_W'(17);
    localparam logic [STATE_W-1:0] JUMP2  = STATE_W'(18);
    localparam logic [STATE_W-1:0] JUMP3  = STATE_W'(19);
    localparam logic [STATE_W-1:0] SKIP1  = STATE_W'(20);
    localparam logic [STATE_W-1:0] SKIP2  = STATE_W'(21);
    localparam logic [STATE_W-1:0] ADD1   = STATE_W'(22);
    localparam logic [STATE_W-1:0] SUB1   = STATE_W'(23);
    localparam logic [STATE_W-1:0] INAC1  = STATE_W'(24);
    localparam logic [STATE_W-1:0] CLAC1  = STATE_W'(25);
    localparam logic [STATE_W-1:0] AND1   = STATE_W'(26);
    localparam logic [STATE_W-1:0] OR1    = STATE_W'(27);
    localparam logic [STATE_W-1:0] XOR1   = STATE_W'(28);
    localparam logic [STATE_W-1:0] NOT1   = STATE_W'(29);

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_MEM  = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DT   = 3'd3;
    localparam logic [2:0] BUS_DR   = 3'd4;
    localparam logic [2:0] BUS_R    = 3'd5;
    localparam logic [2:0] BUS_AC   = 3'd6;

    localparam logic [6:0] ALU_ADD  = 7'b0000101;
    localparam logic [6:0] ALU_SUB  = 7'b0001011;
    localparam logic [6:0] ALU_INC  = 7'b0001001;
    localparam logic [6:0] ALU_CLR  = 7'b0000000;
    localparam logic [6:0] ALU_PASS = 7'b0000100;
    localparam logic [6:0] ALU_AND  = 7'b1000000;
    localparam logic [6:0] ALU_OR   = 7'b1100000;
    localparam logic [6:0] ALU_XOR  = 7'b1010000;
    localparam logic [6:0] ALU_NOT  = 7'b1110000;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic               ready;

    // With the handshake disabled every memory access is treated as
    // completing in the cycle it is issued.
    assign ready     = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
        end else begin
            state <= next_state;
        end
    end

    // Memory states hold until ready; unknown encodings fall back to FETCH1.
    always_comb begin
        next_state = FETCH1;
        case (state)
            S_RST:  next_state = FETCH1;
            FETCH1: next_state = FETCH2;
            FETCH2: next_state = ready ? FETCH3 : FETCH2;
            FETCH3: begin
                if (ir_in[7:4] != 4'h0) begin
                    next_state = NOP1;
                end else begin
                    case (ir_in[3:0])
                        4'h0:    next_state = NOP1;
                        4'h1:    next_state = LDAC1;
                        4'h2:    next_state = STAC1;
                        4'h3:    next_state = MVAC1;
                        4'h4:    next_state = MOVR1;
                        4'h5:    next_state = JUMP1;
                        4'h6:    next_state = z_in ? JUMP1 : SKIP1;
                        4'h7:    next_state = z_in ? SKIP1 : JUMP1;
                        4'h8:    next_state = ADD1;
                        4'h9:    next_state = SUB1;
                        4'hA:    next_state = INAC1;
                        4'hB:    next_state = CLAC1;
                        4'hC:    next_state = AND1;
                        4'hD:    next_state = OR1;
                        4'hE:    next_state = XOR1;
                        default: next_state = NOT1;
                    endcase
                end
            end
            LDAC1:  next_state = ready ? LDAC2 : LDAC1;
            LDAC2:  next_state = ready ? LDAC3 : LDAC2;
            LDAC3:  next_state = LDAC4;
            LDAC4:  next_state = ready ? LDAC5 : LDAC4;
            STAC1:  next_state = ready ? STAC2 : STAC1;
            STAC2:  next_state = ready ? STAC3 : STAC2;
            STAC3:  next_state = STAC4;
            STAC4:  next_state = STAC5;
            STAC5:  next_state = ready ? FETCH1 : STAC5;
            JUMP1:  next_state = ready ? JUMP2 : JUMP1;
            JUMP2:  next_state = ready ? JUMP3 : JUMP2;
            SKIP1:  next_state = SKIP2;
            default: next_state = FETCH1;
        endcase
    end

    // Control decode. In memory-read states the loads/increments that
    // consume the read data wait for ready so a stalled access commits once.
    always_comb begin
        ALUSEL  = ALU_CLR;
        bus_sel = BUS_NONE;
        ar_ld   = 1'b0;
        ar_inc  = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        dr_ld   = 1'b0;
        tr_ld   = 1'b0;
        ir_ld   = 1'b0;
        r_ld    = 1'b0;
        ac_ld   = 1'b0;
        z_ld    = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        case (state)
            FETCH1: begin
                bus_sel = BUS_PC;
                ar_ld   = 1'b1;
            end
            FETCH2: begin
                bus_sel = BUS_MEM;
                mem_rd  = 1'b1;
                dr_ld   = ready;
                pc_inc  = ready;
            end
            FETCH3: begin
                bus_sel = BUS_DR;
                ir_ld   = 1'b1;
                ar_ld   = 1'b1;
            end
            LDAC1, STAC1: begin
                bus_sel = BUS_MEM;
                mem_rd  = 1'b1;
                dr_ld   = ready;
                pc_inc  = ready;
                ar_inc  = ready;
            end
            LDAC2, STAC2: begin
                bus_sel = BUS_MEM;
                mem_rd  = 1'b1;
                tr_ld   = 1'b1;
                dr_ld   = ready;
                pc_inc  = ready;
            end
            LDAC3, STAC3: begin
                bus_sel = BUS_DT;
                ar_ld   = 1'b1;
            end
            LDAC4: begin
                bus_sel = BUS_MEM;
                mem_rd  = 1'b1;
                dr_ld   = ready;
            end
            LDAC5: begin
                bus_sel = BUS_DR;
                ALUSEL  = ALU_PASS;
                ac_ld   = 1'b1;
            end
            STAC4: begin
                bus_sel = BUS_AC;
                dr_ld   = 1'b1;
            end
            STAC5: begin
                bus_sel = BUS_DR;
                mem_wr  = 1'b1;
            end
            MVAC1: begin
                bus_sel = BUS_AC;
                r_ld    = 1'b1;
            end
            MOVR1: begin
                bus_sel = BUS_R;
                ALUSEL  = ALU_PASS;
                ac_ld   = 1'b1;
            end
            JUMP1: begin
                bus_sel = BUS_MEM;
                mem_rd  = 1'b1;
                dr_ld   = ready;
                ar_inc  = ready;
            end
            JUMP2: begin
                bus_sel = BUS_MEM;
                mem_rd  = 1'b1;
                tr_ld   = 1'b1;
                dr_ld   = ready;
            end
            JUMP3: begin
                bus_sel = BUS_DT;
                pc_ld   = 1'b1;
            end
            SKIP1, SKIP2: begin
                pc_inc  = 1'b1;
            end
            ADD1: begin
                bus_sel = BUS_R;
                ALUSEL  = ALU_ADD;
                ac_ld   = 1'b1;
                z_ld    = 1'b1;
            end
            SUB1: begin
                bus_sel = BUS_R;
                ALUSEL  = ALU_SUB;
                ac_ld   = 1'b1;
                z_ld    = 1'b1;
            end
            INAC1: begin
                ALUSEL  = ALU_INC;
                ac_ld   = 1'b1;
                z_ld    = 1'b1;
            end
            CLAC1: begin
                ALUSEL  = ALU_CLR;
                ac_ld   = 1'b1;
                z_ld    = 1'b1;
            end
            AND1: begin
                bus_sel = BUS_R;
                ALUSEL  = ALU_AND;
                ac_ld   = 1'b1;
                z_ld    = 1'b1;
            end
            OR1: begin
                bus_sel = BUS_R;
                ALUSEL  = ALU_OR;
                ac_ld   = 1'b1;
                z_ld    = 1'b1;
            end
            XOR1: begin
                bus_sel = BUS_R;
                ALUSEL  = ALU_XOR;
                ac_ld   = 1'b1;
                z_ld    = 1'b1;
            end
            NOT1: begin
                ALUSEL  = ALU_NOT;
                ac_ld   = 1'b1;
                z_ld    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_rscpu_control_unit.sv
// ---------------------------------------------------------------------------
// tb_rscpu_control_unit
//
// Self-checking bench for rscpu_control_unit. Each scenario task queues the
// expected per-cycle state and output vector together with the inputs for
// that cycle, then walks the queue one clock at a time, driving inputs on the
// falling edge and comparing shortly after.
//
// Output vector layout (22 bits):
//   {ALUSEL[7:1], bus_sel[2:0], ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld,
//    ir_ld, r_ld, ac_ld, z_ld, mem_rd, mem_wr}
// ---------------------------------------------------------------------------
module tb_rscpu_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ir_in = 8'h00;
    logic       z_in = 1'b0;
    logic       mem_ready = 1'b1;
    logic [7:1] ALUSEL;
    logic [2:0] bus_sel;
    logic       ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld;
    logic       ir_ld, r_ld, ac_ld, z_ld, mem_rd, mem_wr;
    logic [5:0] state_dbg;
    logic [21:0] obs;

    always #5 clk = ~clk;

    rscpu_control_unit #(
        .USE_MEM_READY(1),
        .STATE_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ir_in(ir_in),
        .z_in(z_in),
        .mem_ready(mem_ready),
        .ALUSEL(ALUSEL),
        .bus_sel(bus_sel),
        .ar_ld(ar_ld),
        .ar_inc(ar_inc),
        .pc_ld(pc_ld),
        .pc_inc(pc_inc),
        .dr_ld(dr_ld),
        .tr_ld(tr_ld),
        .ir_ld(ir_ld),
        .r_ld(r_ld),
        .ac_ld(ac_ld),
        .z_ld(z_ld),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .state_dbg(state_dbg)
    );

    assign obs = {ALUSEL, bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, tr_ld,
                  ir_ld, r_ld, ac_ld, z_ld, mem_rd, mem_wr};

    // State encodings of the design
    localparam logic [5:0] S_RST = 6'd0,  S_F1 = 6'd1,  S_F2 = 6'd2,  S_F3 = 6'd3;
    localparam logic [5:0] S_NOP = 6'd4,  S_LD1 = 6'd5, S_LD2 = 6'd6, S_LD3 = 6'd7;
    localparam logic [5:0] S_LD4 = 6'd8,  S_LD5 = 6'd9, S_ST1 = 6'd10, S_ST2 = 6'd11;
    localparam logic [5:0] S_ST3 = 6'd12, S_ST4 = 6'd13, S_ST5 = 6'd14, S_MVAC = 6'd15;
    localparam logic [5:0] S_MOVR = 6'd16, S_J1 = 6'd17, S_J2 = 6'd18, S_J3 = 6'd19;
    localparam logic [5:0] S_N1 = 6'd20, S_N2 = 6'd21, S_ADD = 6'd22, S_INAC = 6'd24;

    // Expected output vectors
    localparam logic [21:0] O_ZERO = 22'd0;
    localparam logic [21:0] O_F1   = {7'b0, 3'd2, 12'b1000_0000_0000};
    localparam logic [21:0] O_F2   = {7'b0, 3'd1, 12'b0001_1000_0010};
    localparam logic [21:0] O_F2W  = {7'b0, 3'd1, 12'b0000_0000_0010};
    localparam logic [21:0] O_F3   = {7'b0, 3'd4, 12'b1000_0010_0000};
    localparam logic [21:0] O_LD1  = {7'b0, 3'd1, 12'b0101_1000_0010};
    localparam logic [21:0] O_LD2  = {7'b0, 3'd1, 12'b0001_1100_0010};
    localparam logic [21:0] O_LD3  = {7'b0, 3'd3, 12'b1000_0000_0000};
    localparam logic [21:0] O_LD4  = {7'b0, 3'd1, 12'b0000_1000_0010};
    localparam logic [21:0] O_LD4W = {7'b0, 3'd1, 12'b0000_0000_0010};
    localparam logic [21:0] O_LD5  = {7'b0000100, 3'd4, 12'b0000_0000_1000};
    localparam logic [21:0] O_ST4  = {7'b0, 3'd6, 12'b0000_1000_0000};
    localparam logic [21:0] O_ST5  = {7'b0, 3'd4, 12'b0000_0000_0001};
    localparam logic [21:0] O_J1   = {7'b0, 3'd1, 12'b0100_1000_0010};
    localparam logic [21:0] O_J2   = {7'b0, 3'd1, 12'b0000_1100_0010};
    localparam logic [21:0] O_J3   = {7'b0, 3'd3, 12'b0010_0000_0000};
    localparam logic [21:0] O_N    = {7'b0, 3'd0, 12'b0001_0000_0000};
    localparam logic [21:0] O_MVAC = {7'b0, 3'd6, 12'b0000_0001_0000};
    localparam logic [21:0] O_MOVR = {7'b0000100, 3'd5, 12'b0000_0000_1000};
    localparam logic [21:0] O_ADD  = {7'b0000101, 3'd5, 12'b0000_0000_1100};
    localparam logic [21:0] O_INAC = {7'b0001001, 3'd0, 12'b0000_0000_1100};

    typedef struct {
        string       tag;
        logic [7:0]  ir;
        logic        z;
        logic        rdy;
        logic [5:0]  st;
        logic [21:0] out;
    } entry_t;

    entry_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic push(input string tag, input logic [7:0] ir, input logic z,
                        input logic rdy, input logic [5:0] st, input logic [21:0] out);
        entry_t e;
        e.tag = tag; e.ir = ir; e.z = z; e.rdy = rdy; e.st = st; e.out = out;
        sb.push_back(e);
    endtask

    task automatic push_fetch(input string tag, input logic [7:0] ir, input logic z);
        push({tag, "_f1"}, ir, z, 1'b1, S_F1, O_F1);
        push({tag, "_f2"}, ir, z, 1'b1, S_F2, O_F2);
        push({tag, "_f3"}, ir, z, 1'b1, S_F3, O_F3);
    endtask

    // Reset state, release timing, and abandoning LDAC in LDAC3
    task automatic test_reset();
        entry_t e;
        @(negedge clk);
        #1;
        n_cmp++;
        if (state_dbg !== S_RST || obs !== O_ZERO) begin
            n_bad++;
            $display("[TB] FAIL reset_hold: got state %0d out %b, want %0d %b", state_dbg, obs, S_RST, O_ZERO);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        push("rst_release", 8'h01, 1'b0, 1'b1, S_RST, O_ZERO);
        push_fetch("rst_ldac", 8'h01, 1'b0);
        push("rst_ld1", 8'h01, 1'b0, 1'b1, S_LD1, O_LD1);
        push("rst_ld2", 8'h01, 1'b0, 1'b1, S_LD2, O_LD2);
        push("rst_ld3", 8'h01, 1'b0, 1'b1, S_LD3, O_LD3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            ir_in = e.ir; z_in = e.z; mem_ready = e.rdy;
            #1;
            n_cmp++;
            if (state_dbg !== e.st) begin
                n_bad++;
                $display("[TB] FAIL %s state: got %0d want %0d", e.tag, state_dbg, e.st);
            end
            n_cmp++;
            if (obs !== e.out) begin
                n_bad++;
                $display("[TB] FAIL %s outputs: got %b want %b", e.tag, obs, e.out);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (state_dbg !== S_RST || obs !== O_ZERO) begin
            n_bad++;
            $display("[TB] FAIL reset_async: got state %0d out %b, want %0d %b", state_dbg, obs, S_RST, O_ZERO);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        push("rst_release2", 8'h00, 1'b0, 1'b1, S_RST, O_ZERO);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            ir_in = e.ir; z_in = e.z; mem_ready = e.rdy;
            #1;
            n_cmp++;
            if (state_dbg !== e.st) begin
                n_bad++;
                $display("[TB] FAIL %s state: got %0d want %0d", e.tag, state_dbg, e.st);
            end
            n_cmp++;
            if (obs !== e.out) begin
                n_bad++;
                $display("[TB] FAIL %s outputs: got %b want %b", e.tag, obs, e.out);
            end
        end
    endtask

    // ADD twice in a row: the second fetch shows ADD1 returns to FETCH1
    task automatic test_add();
        entry_t e;
        for (int i = 0; i < 2; i++) begin
            push_fetch("add", 8'h08, 1'b0);
            push("add_ex", 8'h08, 1'b0, 1'b1, S_ADD, O_ADD);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            ir_in = e.ir; z_in = e.z; mem_ready = e.rdy;
            #1;
            n_cmp++;
            if (state_dbg !== e.st) begin
                n_bad++;
                $display("[TB] FAIL %s state: got %0d want %0d", e.tag, state_dbg, e.st);
            end
            n_cmp++;
            if (obs !== e.out) begin
                n_bad++;
                $display("[TB] FAIL %s outputs: got %b want %b", e.tag, obs, e.out);
            end
        end
    endtask

    // SUB, CLAC and the four logic operations
    task automatic test_alu_ops();
        entry_t e;
        logic [7:0] ops  [6] = '{8'h09, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
        logic [6:0] sels [6] = '{7'b0001011, 7'b0000000, 7'b1000000, 7'b1100000, 7'b1010000, 7'b1110000};
        logic [2:0] buses[6] = '{3'd5, 3'd0, 3'd5, 3'd5, 3'd5, 3'd0};
        logic [5:0] sts  [6] = '{6'd23, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29};
        for (int i = 0; i < 6; i++) begin
            push_fetch($sformatf("alu%02h", ops[i]), ops[i], 1'b0);
            push($sformatf("alu%02h_ex", ops[i]), ops[i], 1'b0, 1'b1, sts[i],
                 {sels[i], buses[i], 12'b0000_0000_1100});
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            ir_in = e.ir; z_in = e.z; mem_ready = e.rdy;
            #1;
            n_cmp++;
            if (state_dbg !== e.st) begin
                n_bad++;
                $display("[TB] FAIL %s state: got %0d want %0d", e.tag, state_dbg, e.st);
            end
            n_cmp++;
            if (obs !== e.out) begin
                n_bad++;
                $display("[TB] FAIL %s outputs: got %b want %b", e.tag, obs, e.out);
            end
        end
    endtask

    // LDAC with LDAC4 stalled three cycles: 11 cycles in total
    task automatic test_ldac_wait();
        entry_t e;
        push_fetch("ldw", 8'h01, 1'b0);
        push("ldw_ld1", 8'h01, 1'b0, 1'b1, S_LD1, O_LD1);
        push("ldw_ld2", 8'h01, 1'b0, 1'b1, S_LD2, O_LD2);
        push("ldw_ld3", 8'h01, 1'b0, 1'b1, S_LD3, O_LD3);
        for (int i = 0; i < 3; i++)
            push($sformatf("ldw_ld4_wait%0d", i), 8'h01, 1'b0, 1'b0, S_LD4, O_LD4W);
        push("ldw_ld4_ready", 8'h01, 1'b0, 1'b1, S_LD4, O_LD4);
        push("ldw_ld5", 8'h01, 1'b0, 1'b1, S_LD5, O_LD5);
        push("ldw_next", 8'h00, 1'b0, 1'b1, S_F1, O_F1);
        push("ldw_next_f2", 8'h00, 1'b0, 1'b1, S_F2, O_F2);
        push("ldw_next_f3", 8'h00, 1'b0, 1'b1, S_F3, O_F3);
        push("ldw_next_nop", 8'h00, 1'b0, 1'b1, S_NOP, O_ZERO);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            ir_in = e.ir; z_in = e.z; mem_ready = e.rdy;
            #1;
            n_cmp++;
            if (state_dbg !== e.st) begin
                n_bad++;
                $display("[TB] FAIL %s state: got %0d want %0d", e.tag, state_dbg, e.st);
            end
            n_cmp++;
            if (obs !== e.out) begin
                n_bad++;
                $display("[TB] FAIL %s outputs: got %b want %b", e.tag, obs, e.out);
            end
        end
    endtask

    // JMPZ/JPNZ taken and not taken; Z only matters during FETCH3
    task automatic test_jumps();
        entry_t e;
        push_fetch("jmpz_t", 8'h06, 1'b1);
        push("jmpz_t_j1", 8'h06, 1'b0, 1'b1, S_J1, O_J1);
        push("jmpz_t_j2", 8'h06, 1'b0, 1'b1, S_J2, O_J2);
        push("jmpz_t_j3", 8'h06, 1'b0, 1'b1, S_J3, O_J3);
        push("jmpz_n_f1", 8'h06, 1'b0, 1'b1, S_F1, O_F1);
        push("jmpz_n_f2_wait", 8'h06, 1'b0, 1'b0, S_F2, O_F2W);
        push("jmpz_n_f2", 8'h06, 1'b0, 1'b1, S_F2, O_F2);
        push("jmpz_n_f3", 8'h06, 1'b0, 1'b1, S_F3, O_F3);
        push("jmpz_n_n1", 8'h06, 1'b1, 1'b1, S_N1, O_N);
        push("jmpz_n_n2", 8'h06, 1'b1, 1'b1, S_N2, O_N);
        push_fetch("jpnz_t", 8'h07, 1'b0);
        push("jpnz_t_j1", 8'h07, 1'b1, 1'b1, S_J1, O_J1);
        push("jpnz_t_j2", 8'h07, 1'b1, 1'b1, S_J2, O_J2);
        push("jpnz_t_j3", 8'h07, 1'b1, 1'b1, S_J3, O_J3);
        push_fetch("jpnz_n", 8'h07, 1'b1);
        push("jpnz_n_n1", 8'h07, 1'b0, 1'b1, S_N1, O_N);
        push("jpnz_n_n2", 8'h07, 1'b0, 1'b1, S_N2, O_N);
        push_fetch("jump", 8'h05, 1'b0);
        push("jump_j1", 8'h05, 1'b0, 1'b1, S_J1, O_J1);
        push("jump_j2", 8'h05, 1'b0, 1'b1, S_J2, O_J2);
        push("jump_j3", 8'h05, 1'b0, 1'b1, S_J3, O_J3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            ir_in = e.ir; z_in = e.z; mem_ready = e.rdy;
            #1;
            n_cmp++;
            if (state_dbg !== e.st) begin
                n_bad++;
                $display("[TB] FAIL %s state: got %0d want %0d", e.tag, state_dbg, e.st);
            end
            n_cmp++;
            if (obs !== e.out) begin
                n_bad++;
                $display("[TB] FAIL %s outputs: got %b want %b", e.tag, obs, e.out);
            end
        end
    endtask

    // STAC with a stalled write, then illegal opcode 0x42 as NOP
    task automatic test_stac_illegal();
        entry_t e;
        push_fetch("stac", 8'h02, 1'b0);
        push("stac_s1", 8'h02, 1'b0, 1'b1, S_ST1, O_LD1);
        push("stac_s2", 8'h02, 1'b0, 1'b1, S_ST2, O_LD2);
        push("stac_s3", 8'h02, 1'b0, 1'b1, S_ST3, O_LD3);
        push("stac_s4", 8'h02, 1'b0, 1'b1, S_ST4, O_ST4);
        push("stac_s5_wait", 8'h02, 1'b0, 1'b0, S_ST5, O_ST5);
        push("stac_s5", 8'h02, 1'b0, 1'b1, S_ST5, O_ST5);
        push_fetch("ill42", 8'h42, 1'b0);
        push("ill42_nop", 8'h42, 1'b0, 1'b1, S_NOP, O_ZERO);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            ir_in = e.ir; z_in = e.z; mem_ready = e.rdy;
            #1;
            n_cmp++;
            if (state_dbg !== e.st) begin
                n_bad++;
                $display("[TB] FAIL %s state: got %0d want %0d", e.tag, state_dbg, e.st);
            end
            n_cmp++;
            if (obs !== e.out) begin
                n_bad++;
                $display("[TB] FAIL %s outputs: got %b want %b", e.tag, obs, e.out);
            end
        end
    endtask

    // MVAC, MOVR, INAC, NOP with no gaps between instructions
    task automatic test_back_to_back();
        entry_t e;
        push_fetch("mvac", 8'h03, 1'b0);
        push("mvac_ex", 8'h03, 1'b0, 1'b1, S_MVAC, O_MVAC);
        push_fetch("movr", 8'h04, 1'b0);
        push("movr_ex", 8'h04, 1'b0, 1'b1, S_MOVR, O_MOVR);
        push_fetch("inac", 8'h0A, 1'b0);
        push("inac_ex", 8'h0A, 1'b0, 1'b1, S_INAC, O_INAC);
        push_fetch("nop", 8'h00, 1'b0);
        push("nop_ex", 8'h00, 1'b0, 1'b1, S_NOP, O_ZERO);
        push("after_nop", 8'h00, 1'b0, 1'b1, S_F1, O_F1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            ir_in = e.ir; z_in = e.z; mem_ready = e.rdy;
            #1;
            n_cmp++;
            if (state_dbg !== e.st) begin
                n_bad++;
                $display("[TB] FAIL %s state: got %0d want %0d", e.tag, state_dbg, e.st);
            end
            n_cmp++;
            if (obs !== e.out) begin
                n_bad++;
                $display("[TB] FAIL %s outputs: got %b want %b", e.tag, obs, e.out);
            end
        end
    endtask

    initial begin
        $display("[TB] starting rscpu_control_unit bench");
        test_reset();
        test_add();
        test_alu_ops();
        test_ldac_wait();
        test_jumps();
        test_stac_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
